cp0_exc_ctrl: RTL and testbench

CP0_EXC_CTRL -- requirements
Module: cp0_exc_ctrl

---
 rtl/cp0_exc_ctrl.sv | 120 ++++++++++++
 tb/tb_cp0_exc_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt controller: SR, Cause, EPC and PRId registers,
// interrupt/exception capture into EPC, eret handling and mfc0/mtc0 access.
module cp0_exc_ctrl #(
   parameter logic [31:0] PRID_VALUE = 32'h2019_0707,
   parameter int          HW_LINES   = 6
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [4:0]          A1,
   input  logic [4:0]          A2,
   input  logic [31:0]         DIn,
   input  logic                WE,
   input  logic [31:0]         VPC,
   input  logic                BD,
   input  logic [4:0]          ExcCode,
   input  logic [HW_LINES-1:0] HWInt,
   input  logic                EXLClr,
   output logic                IntReq,
   output logic [31:0]         EPC,
   output logic [31:0]         DOut
);

   typedef enum logic {
      NORMAL  = 1'b0,
      HANDLER = 1'b1
   } state_t;

   state_t              state, state_nx;
   logic [HW_LINES-1:0] im, im_nx;
   logic                ie, ie_nx;
   logic                cause_bd, cause_bd_nx;
   logic [HW_LINES-1:0] cause_ip;
   logic [4:0]          cause_exc, cause_exc_nx;
   logic [31:2]         epc_q, epc_nx;

   logic        exl;
   logic        int_pend;
   logic        exc_pend;
   logic [31:0] vpc_adj;
   logic [31:0] sr_word;
   logic [31:0] cause_word;

   assign exl      = (state == HANDLER);
   assign int_pend = (|(HWInt & im)) & ie & ~exl;
   assign exc_pend = (ExcCode != 5'd0) & ~exl;
   assign IntReq   = int_pend | exc_pend;

   // A branch-delay victim resumes at its branch; VPC=0 wraps to 32'hFFFF_FFFC.
   assign vpc_adj  = BD ? (VPC - 32'd4) : VPC;

   assign sr_word    = {16'h0, im, 8'h0, exl, ie};
   assign cause_word = {cause_bd, 15'h0, cause_ip, 3'h0, cause_exc, 2'b00};
   assign EPC        = {epc_q, 2'b00};

   always_comb begin
      // NOTE: every next-state signal gets its hold value first, so no path
      // through this block can leave one unassigned and infer a latch.
      state_nx     = state;
      im_nx        = im;
      ie_nx        = ie;
      cause_bd_nx  = cause_bd;
      cause_exc_nx = cause_exc;
      epc_nx       = epc_q;

      if (IntReq) begin
         // Capture wins over any concurrent mtc0; interrupt outranks exception.
         state_nx     = HANDLER;
         cause_bd_nx  = BD;
         cause_exc_nx = int_pend ? 5'd0 : ExcCode;
         epc_nx       = vpc_adj[31:2];
      end else begin
         if (WE && (A2 == 5'd12)) begin
            im_nx    = DIn[15:10];
            ie_nx    = DIn[0];
            state_nx = DIn[1] ? HANDLER : NORMAL;
         end
         // eret overrides an SR write's EXL bit but leaves IM/IE intact.
         if (EXLClr) begin
            state_nx = NORMAL;
         end
         if (WE && (A2 == 5'd14)) begin
            epc_nx = DIn[31:2];
         end
      end
   end

   // NOTE: non-blocking assignments keep every register sampling the
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= NORMAL;
         im        <= '0;
         ie        <= 1'b0;
         cause_bd  <= 1'b0;
         cause_ip  <= '0;
         cause_exc <= 5'd0;
         epc_q     <= '0;
      end else begin
         state     <= state_nx;
         im        <= im_nx;
         ie        <= ie_nx;
         cause_bd  <= cause_bd_nx;
         cause_ip  <= HWInt;
         cause_exc <= cause_exc_nx;
         epc_q     <= epc_nx;
      end
   end

   always_comb begin
      DOut = 32'h0;
      unique case (A1)
         5'd12:   DOut = sr_word;
         5'd13:   DOut = cause_word;
         5'd14:   DOut = EPC;
         5'd15:   DOut = PRID_VALUE;
         default: DOut = 32'h0;
      endcase
   end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Scoreboard bench for cp0_exc_ctrl: the driver predicts each cycle's outputs
// from a register-level model and queues them; a negedge monitor compares.
module tb_cp0_exc_ctrl;

   localparam logic [31:0] PRID = 32'h2019_0707;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  A1, A2;
   logic [31:0] DIn;
   logic        WE;
   logic [31:0] VPC;
   logic        BD;
   logic [4:0]  ExcCode;
   logic [5:0]  HWInt;
   logic        EXLClr;
   logic        IntReq;
   logic [31:0] EPC;
   logic [31:0] DOut;

   cp0_exc_ctrl #(.PRID_VALUE(PRID), .HW_LINES(6)) dut (
      .clk(clk), .reset(reset), .A1(A1), .A2(A2), .DIn(DIn), .WE(WE),
      .VPC(VPC), .BD(BD), .ExcCode(ExcCode), .HWInt(HWInt), .EXLClr(EXLClr),
      .IntReq(IntReq), .EPC(EPC), .DOut(DOut)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        intreq;
      logic [31:0] epc;
      logic [31:0] dout;
      bit          ki, ke, kd;
      logic        kint;
      logic [31:0] kepc, kdout;
   } exp_t;

   exp_t q[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   // Architectural model: plain register contents, updated once per edge.
   logic [5:0]  m_im, m_ip;
   logic        m_exl, m_ie, m_bd;
   logic [4:0]  m_exc;
   logic [31:0] m_epc;

   task automatic check(input string name, input string what,
                        input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s.%s: got %h want %h", name, what, got, want);
      end
   endtask

   function automatic logic [31:0] m_sr();
      return {16'h0, m_im, 8'h0, m_exl, m_ie};
   endfunction

   function automatic logic [31:0] m_cause();
      return {m_bd, 15'h0, m_ip, 3'h0, m_exc, 2'b00};
   endfunction

   function automatic logic [31:0] m_read(input logic [4:0] a);
      case (a)
         5'd12:   return m_sr();
         5'd13:   return m_cause();
         5'd14:   return m_epc;
         5'd15:   return PRID;
         default: return 32'h0;
      endcase
   endfunction

   task automatic model_clear();
      m_im = '0; m_ip = '0; m_exl = 0; m_ie = 0; m_bd = 0; m_exc = '0; m_epc = '0;
   endtask

   // Predict this cycle's outputs from current inputs, queue them, advance model.
   task automatic eval(input string name,
                       input bit ki = 0, input logic kint = 0,
                       input bit ke = 0, input logic [31:0] kepc = 0,
                       input bit kd = 0, input logic [31:0] kdout = 0);
      exp_t        e;
      logic        ipend, req;
      logic [31:0] target;
      if (reset) model_clear();
      ipend = ((HWInt & m_im) != 6'd0) && m_ie && !m_exl;
      req   = ipend || ((ExcCode != 5'd0) && !m_exl);
      e.name = name; e.intreq = req; e.epc = m_epc; e.dout = m_read(A1);
      e.ki = ki; e.kint = kint; e.ke = ke; e.kepc = kepc; e.kd = kd; e.kdout = kdout;
      q.push_back(e);
      if (reset) begin
         model_clear();
      end else begin
         m_ip = HWInt;
         if (req) begin
            target = BD ? VPC - 32'd4 : VPC;
            m_exl = 1; m_bd = BD; m_epc = {target[31:2], 2'b00};
            m_exc = ipend ? 5'd0 : ExcCode;
         end else begin
            if (WE && A2 == 5'd12) begin
               m_im = DIn[15:10]; m_ie = DIn[0]; m_exl = DIn[1];
            end
            if (EXLClr) m_exl = 0;
            if (WE && A2 == 5'd14) m_epc = {DIn[31:2], 2'b00};
         end
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
      A1 = 0; A2 = 0; DIn = 0; WE = 0; VPC = 0; BD = 0;
      ExcCode = 0; HWInt = 0; EXLClr = 0;
   endtask

   // Monitor: outputs are stable mid-cycle, so compare on the falling edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() != 0) begin
            e = q.pop_front();
            check(e.name, "IntReq", {31'h0, IntReq}, {31'h0, e.intreq});
            check(e.name, "EPC", EPC, e.epc);
            check(e.name, "DOut", DOut, e.dout);
            if (e.ki) check(e.name, "IntReq_k", {31'h0, IntReq}, {31'h0, e.kint});
            if (e.ke) check(e.name, "EPC_k", EPC, e.kepc);
            if (e.kd) check(e.name, "DOut_k", DOut, e.kdout);
         end
      end
   end

   initial begin
      reset = 1; A1 = 0; A2 = 0; DIn = 0; WE = 0; VPC = 0; BD = 0;
      ExcCode = 0; HWInt = 0; EXLClr = 0;
      model_clear();

      // Reset values.
      next_cycle(); A1 = 15; eval("rst_prid", 1, 0, 1, 0, 1, PRID);
      next_cycle(); reset = 0; A1 = 12; eval("rst_sr", 1, 0, 0, 0, 1, 0);
      next_cycle(); A1 = 13; eval("rst_cause", 1, 0, 0, 0, 1, 0);
      next_cycle(); A1 = 14; eval("rst_epc", 1, 0, 0, 0, 1, 0);

      // Hardware interrupt capture.
      next_cycle(); WE = 1; A2 = 12; DIn = 32'h0000_0401; A1 = 12; eval("int_wr_sr", 1, 0, 0, 0, 1, 0);
      next_cycle(); HWInt = 6'b000001; VPC = 32'h0000_3010; A1 = 12;
      eval("int_req", 1, 1, 0, 0, 1, 32'h0000_0401);
      next_cycle(); HWInt = 6'b000001; A1 = 13;
      eval("int_captured", 1, 0, 1, 32'h0000_3010, 1, 32'h0000_0400);
      next_cycle(); EXLClr = 1; A1 = 12; eval("int_sr_exl", 1, 0, 0, 0, 1, 32'h0000_0403);
      next_cycle(); WE = 1; A2 = 12; DIn = 0; A1 = 12; eval("int_eret", 1, 0, 0, 0, 1, 32'h0000_0401);

      // Synchronous exception in a delay slot.
      next_cycle(); ExcCode = 5'd10; VPC = 32'h0000_3024; BD = 1; A1 = 12;
      eval("exc_req", 1, 1, 0, 0, 1, 0);
      next_cycle(); A1 = 13; eval("exc_cause", 1, 0, 1, 32'h0000_3020, 1, 32'h8000_0028);
      next_cycle(); EXLClr = 1; A1 = 12; eval("exc_exl", 1, 0, 0, 0, 1, 32'h0000_0002);
      next_cycle(); A1 = 12; eval("exc_eret", 1, 0, 0, 0, 1, 0);

      // Interrupt + exception + mtc0 EPC in one cycle.
      next_cycle(); WE = 1; A2 = 12; DIn = 32'h0000_0401; eval("prio_wr_sr");
      next_cycle(); HWInt = 6'b000001; ExcCode = 5'd4; WE = 1; A2 = 14;
      DIn = 32'h1234_5678; VPC = 32'h0000_3030; A1 = 14;
      eval("prio_req", 1, 1, 0, 0, 1, 32'h0000_3020);
      next_cycle(); A1 = 13; eval("prio_result", 1, 0, 1, 32'h0000_3030, 1, 32'h0000_0400);

      // No nested capture while EXL=1; IP still samples.
      next_cycle(); HWInt = 6'h3F; ExcCode = 5'd12; A1 = 14;
      eval("nest_block", 1, 0, 1, 32'h0000_3030, 1, 32'h0000_3030);
      next_cycle(); A1 = 13; eval("nest_ip", 1, 0, 1, 32'h0000_3030, 1, 32'h0000_FC00);

      // Asynchronous reset mid-cycle while EXL=1.
      next_cycle(); EXLClr = 1; eval("ar_eret");
      next_cycle(); WE = 1; A2 = 14; DIn = 32'h0000_3040; eval("ar_wr_epc");
      next_cycle(); WE = 1; A2 = 12; DIn = 32'h0000_0403; A1 = 14;
      eval("ar_wr_sr", 1, 0, 0, 0, 1, 32'h0000_3040);
      next_cycle(); A1 = 12; eval("ar_pre", 1, 0, 1, 32'h0000_3040, 1, 32'h0000_0403);
      next_cycle(); A1 = 12; #1; reset = 1;
      eval("ar_sr", 1, 0, 1, 0, 1, 0);
      next_cycle(); A1 = 13; eval("ar_cause", 1, 0, 1, 0, 1, 0);
      next_cycle(); A1 = 14; eval("ar_epc", 1, 0, 1, 0, 1, 0);

      // Victim PC wrap.
      next_cycle(); reset = 0; ExcCode = 5'd1; VPC = 0; BD = 1; eval("wrap_req", 1, 1);
      next_cycle(); A1 = 13; eval("wrap_epc", 1, 0, 1, 32'hFFFF_FFFC, 1, 32'h8000_0004);

      // eret together with an SR write; ignored writes to 13 and 15.
      next_cycle(); WE = 1; A2 = 12; DIn = 32'h0000_0C03; EXLClr = 1; A1 = 12;
      eval("eret_sr_wr", 1, 0, 0, 0, 1, 32'h0000_0002);
      next_cycle(); A1 = 12; eval("eret_sr_res", 1, 0, 0, 0, 1, 32'h0000_0C01);
      next_cycle(); WE = 1; A2 = 13; DIn = 32'hFFFF_FFFF; A1 = 13;
      eval("wr13", 1, 0, 0, 0, 1, 32'h8000_0004);
      next_cycle(); WE = 1; A2 = 15; DIn = 32'h0; A1 = 13;
      eval("wr13_ign", 1, 0, 0, 0, 1, 32'h8000_0004);
      next_cycle(); A1 = 15; eval("wr15_ign", 1, 0, 0, 0, 1, PRID);

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         next_cycle();
         reset   = ($urandom_range(0, 99) == 0);
         A1      = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'(12 + $urandom_range(0, 3));
         A2      = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'(12 + $urandom_range(0, 3));
         DIn     = $urandom;
         WE      = ($urandom_range(0, 3) == 0);
         BD      = $urandom_range(0, 1);
         VPC     = ($urandom_range(0, 15) == 0) ? 32'h0 : $urandom;
         ExcCode = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
         HWInt   = ($urandom_range(0, 2) == 0) ? 6'($urandom_range(0, 63)) : 6'd0;
         EXLClr  = ($urandom_range(0, 6) == 0);
         eval("rand");
      end

      next_cycle(); reset = 0; eval("idle");
      next_cycle();
      @(negedge clk);
      #1;
      check("drain", "queue_left", q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
